// File: rtl/tdc_word_aligner_if.sv
// Bus bundle between the upstream data-shift stage and the word aligner.
// The aligner is the slave: it receives frames and strobes and drives the
// bit-slip selection and status back.
interface tdc_word_aligner_if;
  logic        tick;
  logic        force_realign;
  logic [39:0] data_40b;
  logic [3:0]  shift;
  logic        aligned;
  logic [7:0]  slip_cnt;
  logic [7:0]  loss_cnt;

  modport master (
    output tick, force_realign, data_40b,
    input  shift, aligned, slip_cnt, loss_cnt
  );

  modport slave (
    input  tick, force_realign, data_40b,
    output shift, aligned, slip_cnt, loss_cnt
  );
endinterface

// File: rtl/tdc_word_aligner.sv
// K28.5 comma word aligner. Hunts for a comma in symbol slot 0 by stepping
// the upstream bit-slip selection, waits a few frames after every slip for the
// shift stage to settle, declares lock after a run of good frames and drops it
// after a run of bad frames. Only frames flagged by tick are evaluated.
module tdc_word_aligner #(
  parameter int SETTLE_TICKS = 3,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input logic               clk,
  input logic               rst,
  tdc_word_aligner_if.slave align_if
);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Counters compare their pre-increment value against the last index so the
  // transition happens on exactly the Nth qualifying tick.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);
  localparam logic [3:0] SHIFT_MAX   = 4'd9;

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  function automatic logic is_comma(input logic [9:0] sym);
    return (sym == K28_5_NEG) || (sym == K28_5_POS);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [7:0] bad_cnt_q, bad_cnt_d;
  logic [3:0] shift_q, shift_d;
  logic       aligned_q, aligned_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       good_s;
  logic       unused_data_s;

  assign good_s        = is_comma(align_if.data_40b[9:0]);
  assign unused_data_s = ^align_if.data_40b[39:10];

  // Next-state logic: force_realign overrides any tick; otherwise only ticks advance.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    shift_d      = shift_q;
    aligned_d    = aligned_q;
    slip_cnt_d   = slip_cnt_q;
    loss_cnt_d   = loss_cnt_q;

    if (align_if.force_realign) begin
      state_d      = ST_SETTLE;
      settle_cnt_d = 4'd0;
      good_cnt_d   = 8'd0;
      bad_cnt_d    = 8'd0;
      aligned_d    = 1'b0;
    end else if (align_if.tick) begin
      case (state_q)
        ST_SETTLE: begin
          // Data is meaningless while the shift stage settles.
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_CHECK;
            settle_cnt_d = 4'd0;
            good_cnt_d   = 8'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
        ST_CHECK: begin
          if (good_s) begin
            if (good_cnt_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              good_cnt_d = 8'd0;
              bad_cnt_d  = 8'd0;
              aligned_d  = 1'b1;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            // Slip one bit and give the upstream stage time to follow.
            if (shift_q == SHIFT_MAX) begin
              shift_d = 4'd0;
            end else begin
              shift_d = shift_q + 4'd1;
            end
            slip_cnt_d   = sat_inc(slip_cnt_q);
            good_cnt_d   = 8'd0;
            settle_cnt_d = 4'd0;
            state_d      = ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          if (good_s) begin
            bad_cnt_d = 8'd0;
          end else if (bad_cnt_q == UNLOCK_LAST) begin
            // Lock lost: re-qualify at the current shift before slipping.
            state_d    = ST_CHECK;
            bad_cnt_d  = 8'd0;
            good_cnt_d = 8'd0;
            aligned_d  = 1'b0;
            loss_cnt_d = sat_inc(loss_cnt_q);
          end else begin
            bad_cnt_d = bad_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = 4'd0;
          good_cnt_d   = 8'd0;
          bad_cnt_d    = 8'd0;
          aligned_d    = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= 4'd0;
      good_cnt_q   <= 8'd0;
      bad_cnt_q    <= 8'd0;
      shift_q      <= 4'd0;
      aligned_q    <= 1'b0;
      slip_cnt_q   <= 8'd0;
      loss_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      shift_q      <= shift_d;
      aligned_q    <= aligned_d;
      slip_cnt_q   <= slip_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign align_if.shift    = shift_q;
  assign align_if.aligned  = aligned_q;
  assign align_if.slip_cnt = slip_cnt_q;
  assign align_if.loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_tdc_word_aligner.sv
// Self-checking bench for tdc_word_aligner with default parameters. The
// upstream shift stage is modelled as "comma appears in slot 0 only when the
// aligner's shift equals a chosen target".
module tb_tdc_word_aligner;

  localparam int SETTLE_TICKS = 3;
  localparam int LOCK_COUNT   = 8;
  localparam int UNLOCK_COUNT = 4;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;

  typedef enum int {M_SETTLE, M_CHECK, M_LOCKED} mode_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  mode_t m_mode;
  int    m_settle, m_good, m_bad, m_shift, m_slip, m_loss;
  bit    m_aligned;

  tdc_word_aligner_if bus ();

  tdc_word_aligner #(
    .SETTLE_TICKS(SETTLE_TICKS),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .align_if(bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: run lengths counted up to their thresholds.
  task automatic model_step(input bit r, input bit t, input bit f, input logic [39:0] d);
    bit good;
    good = (d[9:0] == K_NEG) || (d[9:0] == K_POS);
    if (r) begin
      m_mode = M_SETTLE; m_settle = 0; m_good = 0; m_bad = 0;
      m_shift = 0; m_slip = 0; m_loss = 0; m_aligned = 0;
    end else if (f) begin
      m_mode = M_SETTLE; m_settle = 0; m_good = 0; m_bad = 0; m_aligned = 0;
    end else if (t) begin
      case (m_mode)
        M_SETTLE: begin
          m_settle++;
          if (m_settle == SETTLE_TICKS) begin m_mode = M_CHECK; m_settle = 0; m_good = 0; end
        end
        M_CHECK: begin
          if (good) begin
            m_good++;
            if (m_good == LOCK_COUNT) begin m_mode = M_LOCKED; m_aligned = 1; m_bad = 0; m_good = 0; end
          end else begin
            m_shift = (m_shift + 1) % 10;
            m_slip  = (m_slip < 255) ? m_slip + 1 : 255;
            m_good = 0; m_settle = 0; m_mode = M_SETTLE;
          end
        end
        default: begin
          if (good) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == UNLOCK_COUNT) begin
              m_aligned = 0; m_loss = (m_loss < 255) ? m_loss + 1 : 255;
              m_mode = M_CHECK; m_good = 0; m_bad = 0;
            end
          end
        end
      endcase
    end
  endtask

  // Upstream shift stage: comma in slot 0 only when the fed-back shift hits target.
  function automatic logic [39:0] mk_data(input int target, input bit bad);
    logic [39:0] d;
    logic [9:0]  s;
    d[31:0]  = $urandom;
    d[39:32] = 8'($urandom);
    if (!bad && (int'(bus.shift) == target)) begin
      s = ($urandom_range(0, 1) == 0) ? K_NEG : K_POS;
    end else begin
      s = 10'($urandom);
      if ((s == K_NEG) || (s == K_POS)) s = s ^ 10'h001;
    end
    d[9:0] = s;
    return d;
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus.aligned, bus.shift, bus.slip_cnt, bus.loss_cnt};
  endfunction

  function automatic logic [20:0] mdl_vec();
    return {m_aligned, 4'(m_shift), 8'(m_slip), 8'(m_loss)};
  endfunction

  // Drive one clock cycle; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step(input bit r, input bit t, input bit f, input logic [39:0] d);
    rst = r; bus.tick = t; bus.force_realign = f; bus.data_40b = d;
    @(posedge clk);
    model_step(r, t, f, d);
    #1;
    rst = 1'b0; bus.tick = 1'b0; bus.force_realign = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, i[0], mk_data(0, 1'b0));
      n_checks++;
      if (dut_vec() !== 21'd0) $display("FAIL reset cyc %0d: got %h want %h", i, dut_vec(), 21'd0);
      else n_pass++;
    end
  endtask

  task automatic test_lock_slot0();
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(0, 1'b0));
      n_checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL lock_slot0 tick %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
      if (i == 10) begin
        n_checks++;
        if (bus.aligned !== 1'b0) $display("FAIL lock_slot0_early: aligned %b want 0", bus.aligned);
        else n_pass++;
      end
    end
    n_checks++;
    if ({bus.aligned, bus.shift, bus.slip_cnt} !== {1'b1, 4'd0, 8'd0})
      $display("FAIL lock_slot0_final: got a=%b s=%0d slip=%0d want a=1 s=0 slip=0", bus.aligned, bus.shift, bus.slip_cnt);
    else n_pass++;
  endtask

  task automatic test_slip_to_6();
    int prev;
    step(1'b1, 1'b0, 1'b0, 40'd0);
    prev = 0;
    for (int i = 0; i < 35; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'b0, 1'b0, mk_data(6, 1'b0));
      step(1'b0, 1'b1, 1'b0, mk_data(6, 1'b0));
      n_checks++;
      if ((dut_vec() !== mdl_vec()) || ((int'(bus.shift) != prev) && (int'(bus.shift) != prev + 1)))
        $display("FAIL slip6 tick %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
      prev = int'(bus.shift);
    end
    n_checks++;
    if ({bus.aligned, bus.shift, bus.slip_cnt} !== {1'b1, 4'd6, 8'd6})
      $display("FAIL slip6_final: got a=%b s=%0d slip=%0d want a=1 s=6 slip=6", bus.aligned, bus.shift, bus.slip_cnt);
    else n_pass++;
  endtask

  task automatic test_no_comma();
    bit wrap_seen;
    bit ever_aligned;
    logic [3:0] prev;
    step(1'b1, 1'b0, 1'b0, 40'd0);
    wrap_seen = 0; ever_aligned = 0; prev = bus.shift;
    for (int i = 0; i < 1100; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(15, 1'b0));
      if (prev == 4'd9 && bus.shift == 4'd0) wrap_seen = 1;
      if (bus.aligned) ever_aligned = 1;
      prev = bus.shift;
      n_checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL no_comma tick %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
    n_checks++;
    if (!wrap_seen || ever_aligned || bus.slip_cnt !== 8'd255)
      $display("FAIL no_comma_final: wrap=%b ever_aligned=%b slip=%0d want wrap=1 aligned=0 slip=255",
               wrap_seen, ever_aligned, bus.slip_cnt);
    else n_pass++;
  endtask

  task automatic test_unlock();
    step(1'b1, 1'b0, 1'b0, 40'd0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, mk_data(0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(0, i < 3));
      n_checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL unlock_isolated %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
    n_checks++;
    if ({bus.aligned, bus.loss_cnt} !== {1'b1, 8'd0})
      $display("FAIL unlock_hold: got a=%b loss=%0d want a=1 loss=0", bus.aligned, bus.loss_cnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, mk_data(0, 1'b1));
    n_checks++;
    if ({bus.aligned, bus.loss_cnt, bus.shift} !== {1'b0, 8'd1, 4'd0})
      $display("FAIL unlock_drop: got a=%b loss=%0d s=%0d want a=0 loss=1 s=0", bus.aligned, bus.loss_cnt, bus.shift);
    else n_pass++;
    // Straight back into CHECK: relock after exactly LOCK_COUNT good ticks, no settle.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(0, 1'b0));
      n_checks++;
      if (bus.aligned !== (i == 8)) $display("FAIL unlock_recheck tick %0d: aligned %b want %b", i, bus.aligned, i == 8);
      else n_pass++;
    end
  endtask

  task automatic test_force();
    int budget;
    step(1'b1, 1'b0, 1'b0, 40'd0);
    budget = 0;
    while (!m_aligned && budget < 200) begin
      step(1'b0, 1'b1, 1'b0, mk_data(6, 1'b0));
      budget++;
    end
    n_checks++;
    if (dut_vec() !== mdl_vec() || !m_aligned) $display("FAIL force_prelock: got %h want %h", dut_vec(), mdl_vec());
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, mk_data(6, 1'b1));
    n_checks++;
    if ({bus.aligned, bus.shift, bus.loss_cnt} !== {1'b0, 4'd6, 8'd0})
      $display("FAIL force_edge: got a=%b s=%0d loss=%0d want a=0 s=6 loss=0", bus.aligned, bus.shift, bus.loss_cnt);
    else n_pass++;
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(6, 1'b0));
      n_checks++;
      if (bus.aligned !== (i == 11) || dut_vec() !== mdl_vec())
        $display("FAIL force_relock tick %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_midlock();
    step(1'b1, 1'b1, 1'b0, mk_data(6, 1'b0));
    n_checks++;
    if ({bus.aligned, bus.shift, bus.slip_cnt} !== {1'b0, 4'd0, 8'd0})
      $display("FAIL reset_midlock: got a=%b s=%0d slip=%0d want 0/0/0", bus.aligned, bus.shift, bus.slip_cnt);
    else n_pass++;
    for (int i = 0; i < 35; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(6, 1'b0));
      n_checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL reset_relock tick %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
  endtask

  task automatic test_tick_idle();
    int stops [4] = '{1, 14, 18, 30};
    int done;
    logic [20:0] snap;
    step(1'b1, 1'b0, 1'b0, 40'd0);
    done = 0;
    for (int s = 0; s < 4; s++) begin
      while (done < stops[s]) begin
        step(1'b0, 1'b1, 1'b0, mk_data(3, 1'b0));
        done++;
      end
      snap = mdl_vec();
      for (int c = 0; c < 100; c++) step(1'b0, 1'b0, 1'b0, mk_data(3, c[0]));
      n_checks++;
      if (dut_vec() !== snap) $display("FAIL tick_idle stop %0d: got %h want %h", s, dut_vec(), snap);
      else n_pass++;
    end
    // Internal counts must also have held: continue and compare against the model.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, mk_data(3, i < 5));
      n_checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL tick_idle_after %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int target;
    step(1'b1, 1'b0, 1'b0, 40'd0);
    target = $urandom_range(0, 9);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) target = $urandom_range(0, 9);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
           mk_data(target, $urandom_range(0, 9) == 0));
      n_checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.force_realign = 1'b0;
    bus.data_40b = 40'd0;
    #1;
    test_reset();
    test_lock_slot0();
    test_slip_to_6();
    test_no_comma();
    test_unlock();
    test_force();
    test_reset_midlock();
    test_tick_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
